// File: rtl/orion_types.sv
// rtl/orion_types.sv - shared widths and types for the memory arbiter
package orion_types;
  localparam int ADDRW = 32;
  localparam int XLEN  = 32;
  localparam int MASKW = 4;

  typedef struct packed {
    logic [ADDRW-1:0] addr;
    logic [XLEN-1:0]  wdata;
    logic [MASKW-1:0] mask;
    logic             we;
  } mem_req_t;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GNT_I = 2'd1,
    ARB_GNT_D = 2'd2
  } arb_state_t;
endpackage

// File: rtl/pipe_reg.sv
// rtl/pipe_reg.sv - enable-gated register with synchronous active-high clear
module pipe_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (en_i) q_d = d_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q_o = q_q;
endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - I$/D$ to single backing port arbiter, D preferred with I starvation guard
module mem_arbiter
  import orion_types::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [ADDRW-1:0] imem_addr_i,
  input  logic             imem_valid_i,
  output logic [XLEN-1:0]  imem_rdata_o,
  output logic             imem_resp_o,
  input  logic [ADDRW-1:0] dmem_addr_i,
  input  logic [XLEN-1:0]  dmem_wdata_i,
  input  logic [MASKW-1:0] dmem_mask_i,
  input  logic             dmem_we_i,
  input  logic             dmem_valid_i,
  output logic [XLEN-1:0]  dmem_rdata_o,
  output logic             dmem_resp_o,
  output logic [ADDRW-1:0] mem_addr_o,
  output logic [XLEN-1:0]  mem_wdata_o,
  output logic [MASKW-1:0] mem_mask_o,
  output logic             mem_we_o,
  output logic             mem_valid_o,
  input  logic [XLEN-1:0]  mem_rdata_i,
  input  logic             mem_resp_i
);
  localparam int CNTW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNTW-1:0] STARVE_MAX = CNTW'(STARVE_LIMIT);

  arb_state_t      state_q, state_d;
  logic [CNTW-1:0] starve_q, starve_d;
  logic            grant_en;
  logic            imem_starved;
  mem_req_t        req_d, req_q;
  logic [$bits(mem_req_t)-1:0] req_bits;

  always_comb begin
    state_d      = state_q;
    starve_d     = starve_q;
    grant_en     = 1'b0;
    req_d        = '0;
    imem_starved = imem_valid_i && (starve_q == STARVE_MAX);
    case (state_q)
      ARB_IDLE: begin
        if (dmem_valid_i && !imem_starved) begin
          state_d  = ARB_GNT_D;
          grant_en = 1'b1;
          req_d    = '{addr: dmem_addr_i, wdata: dmem_wdata_i, mask: dmem_mask_i, we: dmem_we_i};
          // Only losses against a waiting fetch count toward starvation.
          if (imem_valid_i && starve_q != STARVE_MAX) starve_d = starve_q + CNTW'(1);
        end else if (imem_valid_i) begin
          state_d  = ARB_GNT_I;
          grant_en = 1'b1;
          req_d    = '{addr: imem_addr_i, wdata: '0, mask: '1, we: 1'b0};
          starve_d = '0;
        end
      end
      default: begin
        if (mem_resp_i) state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ARB_IDLE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  pipe_reg #(.WIDTH($bits(mem_req_t))) u_req (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (grant_en),
    .d_i   (req_d),
    .q_o   (req_bits)
  );

  assign req_q       = mem_req_t'(req_bits);
  assign mem_addr_o  = req_q.addr;
  assign mem_wdata_o = req_q.wdata;
  assign mem_mask_o  = req_q.mask;
  assign mem_we_o    = req_q.we;
  assign mem_valid_o = (state_q != ARB_IDLE);

  // Response is steered combinationally to the owner so zero-wait memories add no latency.
  assign imem_resp_o  = (state_q == ARB_GNT_I) && mem_resp_i;
  assign imem_rdata_o = (state_q == ARB_GNT_I) ? mem_rdata_i : '0;
  assign dmem_resp_o  = (state_q == ARB_GNT_D) && mem_resp_i;
  assign dmem_rdata_o = (state_q == ARB_GNT_D) ? mem_rdata_i : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized self-checking bench for mem_arbiter against a transaction-level model
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] imem_addr_i = '0;
  logic        imem_valid_i = 1'b0;
  logic [31:0] imem_rdata_o;
  logic        imem_resp_o;
  logic [31:0] dmem_addr_i = '0;
  logic [31:0] dmem_wdata_i = '0;
  logic [3:0]  dmem_mask_i = '0;
  logic        dmem_we_i = 1'b0;
  logic        dmem_valid_i = 1'b0;
  logic [31:0] dmem_rdata_o;
  logic        dmem_resp_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_mask_o;
  logic        mem_we_o;
  logic        mem_valid_o;
  logic [31:0] mem_rdata_i = '0;
  logic        mem_resp_i = 1'b0;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .imem_addr_i  (imem_addr_i),
    .imem_valid_i (imem_valid_i),
    .imem_rdata_o (imem_rdata_o),
    .imem_resp_o  (imem_resp_o),
    .dmem_addr_i  (dmem_addr_i),
    .dmem_wdata_i (dmem_wdata_i),
    .dmem_mask_i  (dmem_mask_i),
    .dmem_we_i    (dmem_we_i),
    .dmem_valid_i (dmem_valid_i),
    .dmem_rdata_o (dmem_rdata_o),
    .dmem_resp_o  (dmem_resp_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_mask_o   (mem_mask_o),
    .mem_we_o     (mem_we_o),
    .mem_valid_o  (mem_valid_o),
    .mem_rdata_i  (mem_rdata_i),
    .mem_resp_i   (mem_resp_i)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Transaction-level model: who owns the port, what was latched, how long imem has waited.
  int          owner = 0;   // 0 none, 1 fetch, 2 data
  int          starve = 0;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_mask;
  logic        m_we;
  logic        prev_valid = 1'b0;
  logic [31:0] grants[$];

  task automatic step(input bit r, input bit iv, input logic [31:0] ia,
                      input bit dv, input logic [31:0] da, input logic [31:0] dw,
                      input logic [3:0] dm, input bit dwe,
                      input bit mr, input logic [31:0] mrd);
    @(negedge clk);
    rst_i = r; imem_valid_i = iv; imem_addr_i = ia;
    dmem_valid_i = dv; dmem_addr_i = da; dmem_wdata_i = dw; dmem_mask_i = dm; dmem_we_i = dwe;
    mem_resp_i = mr; mem_rdata_i = mrd;
    #1;
    check("mem_valid", {31'b0, mem_valid_o}, {31'b0, owner != 0});
    if (owner != 0) begin
      check("mem_addr", mem_addr_o, m_addr);
      check("mem_wdata", mem_wdata_o, m_wdata);
      check("mem_mask", {28'b0, mem_mask_o}, {28'b0, m_mask});
      check("mem_we", {31'b0, mem_we_o}, {31'b0, m_we});
    end
    check("imem_resp", {31'b0, imem_resp_o}, {31'b0, owner == 1 && mr});
    check("imem_rdata", imem_rdata_o, owner == 1 ? mrd : 32'h0);
    check("dmem_resp", {31'b0, dmem_resp_o}, {31'b0, owner == 2 && mr});
    check("dmem_rdata", dmem_rdata_o, owner == 2 ? mrd : 32'h0);
    if (mem_valid_o && !prev_valid) grants.push_back(mem_addr_o);
    prev_valid = mem_valid_o;
    if (r) begin
      owner = 0; starve = 0;
      m_addr = '0; m_wdata = '0; m_mask = '0; m_we = 1'b0;
    end else if (owner == 0) begin
      if (dv && !(iv && starve == LIMIT)) begin
        owner = 2;
        if (iv && starve < LIMIT) starve = starve + 1;
        m_addr = da; m_wdata = dw; m_mask = dm; m_we = dwe;
      end else if (iv) begin
        owner = 1; starve = 0;
        m_addr = ia; m_wdata = '0; m_mask = 4'hF; m_we = 1'b0;
      end
    end else if (mr) begin
      owner = 0;
    end
  endtask

  task automatic idle(input bit r);
    step(r, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  int lat;
  bit mr;

  initial begin
    idle(1); idle(1);
    idle(0);
    check("rst_addr", mem_addr_o, 32'h0);
    check("rst_wdata", mem_wdata_o, 32'h0);
    check("rst_mask", {28'b0, mem_mask_o}, 32'h0);
    check("rst_we", {31'b0, mem_we_o}, 32'h0);

    // Fetch only, one-cycle memory latency.
    step(0, 1, 32'h8000_0000, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
    check("t1_valid", {31'b0, mem_valid_o}, 32'h1);
    check("t1_addr", mem_addr_o, 32'h8000_0000);
    check("t1_mask", {28'b0, mem_mask_o}, 32'hF);
    step(0, 0, 32'h0, 0, 0, 0, 0, 0, 1, 32'h0000_0013);
    check("t1_resp", {31'b0, imem_resp_o}, 32'h1);
    check("t1_rdata", imem_rdata_o, 32'h13);
    idle(0);
    check("t1_done", {31'b0, mem_valid_o}, 32'h0);

    // Store, then input-hold: dmem_addr changes while granted.
    step(0, 0, 0, 1, 32'h8000_0100, 32'hDEAD_BEEF, 4'b0011, 1, 0, 0);
    step(0, 0, 0, 1, 32'h8000_0200, 32'h1111_2222, 4'b1100, 0, 0, 0);
    check("t2_addr", mem_addr_o, 32'h8000_0100);
    check("t2_wdata", mem_wdata_o, 32'hDEAD_BEEF);
    check("t2_we", {31'b0, mem_we_o}, 32'h1);
    step(0, 0, 0, 0, 32'h8000_0200, 0, 0, 0, 1, 32'h5);
    check("t2_resp", {31'b0, dmem_resp_o}, 32'h1);
    idle(0);

    // Both requesting continuously, zero-wait memory: D,D,D,D,I,D.
    grants.delete();
    for (int i = 0; i < 14; i++)
      step(0, 1, 32'h1000, 1, 32'h2000, 0, 4'hF, 0, owner != 0, 32'hA0 + i);
    check("starve_n", grants.size() >= 6 ? 32'd6 : grants.size(), 32'd6);
    if (grants.size() >= 6)
      for (int i = 0; i < 6; i++)
        check("starve_order", grants[i], (i == 4) ? 32'h1000 : 32'h2000);
    idle(0); idle(0);

    // Reset during a 3-cycle data transaction; the late response must be dropped.
    step(0, 0, 0, 1, 32'h300, 32'h7, 4'hF, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h99);
    check("t6_valid", {31'b0, mem_valid_o}, 32'h0);
    check("t6_dresp", {31'b0, dmem_resp_o}, 32'h0);
    check("t6_iresp", {31'b0, imem_resp_o}, 32'h0);

    // Randomized traffic with a 0..3 cycle memory and occasional resets.
    lat = 0;
    for (int i = 0; i < 3000; i++) begin
      if (owner != 0) begin
        mr = (lat == 0);
        if (lat > 0) lat--;
      end else begin
        mr = ($urandom_range(0, 7) == 0);
        lat = $urandom_range(0, 3);
      end
      step($urandom_range(0, 99) == 0, $urandom_range(0, 2) != 0, $urandom,
           $urandom_range(0, 2) != 0, $urandom, $urandom, 4'($urandom), 1'($urandom),
           mr, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
